// File: rtl/fir_coeff_loader.sv
// Coefficient bank loader: shadow-fills P_NUM_COEFF words, commits them atomically, and
// generates the 300 kHz sample strobe. Define FIR_COEFF_CHECKSUM_EN to add a trailing checksum word.
//
// state  | meaning
// IDLE   | bank stable, sample strobe allowed, waiting for iLoadStart
// LOAD   | accepting coefficient words into the shadow bank
// CHECK  | accepting the checksum word (FIR_COEFF_CHECKSUM_EN only)
// COMMIT | one cycle: shadow bank copied to oCoeffBus, multipliers enabled
module fir_coeff_loader #(
    parameter int P_NUM_COEFF = 12,
    parameter int P_DIV       = 40
) (
    input  logic                      iClk_12M,
    input  logic                      iRst,
    input  logic                      iLoadStart,
    input  logic                      iCoeffValid,
    input  logic [15:0]               iCoeffData,
    output logic                      oCoeffReady,
    output logic [16*P_NUM_COEFF-1:0] oCoeffBus,
    output logic [3:0]                oEnMul,
    output logic                      oEnSample_300k,
    output logic                      oBusy,
    output logic                      oLoadDone,
    output logic                      oLoadErr
);

    localparam int IDX_W = (P_NUM_COEFF > 1) ? $clog2(P_NUM_COEFF) : 1;
    localparam int CNT_W = (P_DIV > 1) ? $clog2(P_DIV) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(P_NUM_COEFF - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(P_DIV - 1);

`ifdef FIR_COEFF_CHECKSUM_EN
    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, COMMIT = 2'd2, CHECK = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, COMMIT = 2'd2} state_t;
`endif

    state_t            state;
    logic [IDX_W-1:0]  idx;
    logic [CNT_W-1:0]  cnt;
    logic [15:0]       shadow [P_NUM_COEFF];

    // Free-running divider; never restarted by a load so the sample grid stays fixed
    always_ff @(posedge iClk_12M) begin
        if (iRst) begin
            cnt <= '0;
        end else if (cnt == LAST_CNT) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign oBusy          = (state != IDLE);
    assign oEnSample_300k = (cnt == LAST_CNT) && (state == IDLE);

`ifdef FIR_COEFF_CHECKSUM_EN
    logic [15:0] sum;
    logic        load_err;

    assign oCoeffReady = (state == LOAD) || (state == CHECK);
    assign oLoadErr    = load_err;
`else
    assign oCoeffReady = (state == LOAD);
    assign oLoadErr    = 1'b0;
`endif

    always_ff @(posedge iClk_12M) begin
        if (iRst) begin
            state     <= IDLE;
            idx       <= '0;
            oEnMul    <= 4'h0;
            oLoadDone <= 1'b0;
            oCoeffBus <= '0;
            for (int k = 0; k < P_NUM_COEFF; k++) begin
                shadow[k] <= 16'h0000;
            end
`ifdef FIR_COEFF_CHECKSUM_EN
            sum      <= 16'h0000;
            load_err <= 1'b0;
`endif
        end else begin
            oLoadDone <= 1'b0;
            case (state)
                IDLE: begin
                    if (iLoadStart) begin
                        state  <= LOAD;
                        idx    <= '0;
                        oEnMul <= 4'h0;
`ifdef FIR_COEFF_CHECKSUM_EN
                        sum    <= 16'h0000;
`endif
                    end
                end
                LOAD: begin
                    if (iCoeffValid) begin
                        shadow[idx] <= iCoeffData;
`ifdef FIR_COEFF_CHECKSUM_EN
                        sum         <= sum + iCoeffData;
`endif
                        if (idx == LAST_IDX) begin
                            idx   <= '0;
`ifdef FIR_COEFF_CHECKSUM_EN
                            state <= CHECK;
`else
                            state <= COMMIT;
`endif
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
`ifdef FIR_COEFF_CHECKSUM_EN
                CHECK: begin
                    if (iCoeffValid) begin
                        if (iCoeffData == sum) begin
                            state <= COMMIT;
                        end else begin
                            // Rejected load: live bank untouched, multipliers stay off
                            state    <= IDLE;
                            load_err <= 1'b1;
                        end
                    end
                end
`endif
                COMMIT: begin
                    for (int k = 0; k < P_NUM_COEFF; k++) begin
                        oCoeffBus[16*k +: 16] <= shadow[k];
                    end
                    oEnMul    <= 4'hF;
                    oLoadDone <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Randomized bench for fir_coeff_loader: a word-queue reference model predicts every output
// each cycle; scenario checks cover idle strobes, loads, checksum reject, mid-load reset.
module tb_fir_coeff_loader;

    localparam int N   = 12;
    localparam int DIV = 40;
    localparam int BW  = 16 * N;
`ifdef FIR_COEFF_CHECKSUM_EN
    localparam int CHK = 1;
`else
    localparam int CHK = 0;
`endif
    localparam int NT = N + CHK;

    logic          iClk_12M = 1'b0;
    logic          iRst = 1'b1;
    logic          iLoadStart = 1'b0;
    logic          iCoeffValid = 1'b0;
    logic [15:0]   iCoeffData = 16'h0;
    logic          oCoeffReady;
    logic [BW-1:0] oCoeffBus;
    logic [3:0]    oEnMul;
    logic          oEnSample_300k;
    logic          oBusy;
    logic          oLoadDone;
    logic          oLoadErr;

    fir_coeff_loader #(.P_NUM_COEFF(N), .P_DIV(DIV)) dut (
        .iClk_12M       (iClk_12M),
        .iRst           (iRst),
        .iLoadStart     (iLoadStart),
        .iCoeffValid    (iCoeffValid),
        .iCoeffData     (iCoeffData),
        .oCoeffReady    (oCoeffReady),
        .oCoeffBus      (oCoeffBus),
        .oEnMul         (oEnMul),
        .oEnSample_300k (oEnSample_300k),
        .oBusy          (oBusy),
        .oLoadDone      (oLoadDone),
        .oLoadErr       (oLoadErr)
    );

    always #5 iClk_12M = ~iClk_12M;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            if (failures <= 20)
                $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: phase 0 idle, 1 collecting words, 2 awaiting checksum, 3 committing
    int            m_phase = 0;
    logic [15:0]   m_words[$];
    logic [BW-1:0] m_bank = '0;
    logic [3:0]    m_en = 4'h0;
    logic          m_done = 1'b0;
    logic          m_err = 1'b0;
    int            m_cnt = 0;

    function automatic logic [15:0] words_sum();
        int s = 0;
        foreach (m_words[i]) s += int'(m_words[i]);
        return 16'(s % 65536);
    endfunction

    task automatic model_step();
        bit xfer;
        if (iRst) begin
            m_phase = 0; m_words.delete(); m_bank = '0; m_en = 4'h0;
            m_done = 1'b0; m_err = 1'b0; m_cnt = 0;
            return;
        end
        xfer = iCoeffValid && (m_phase == 1 || m_phase == 2);
        m_done = 1'b0;
        m_cnt = (m_cnt + 1) % DIV;
        case (m_phase)
            0: if (iLoadStart) begin m_phase = 1; m_words.delete(); m_en = 4'h0; end
            1: if (xfer) begin
                m_words.push_back(iCoeffData);
                if (m_words.size() == N) m_phase = (CHK != 0) ? 2 : 3;
            end
            2: if (xfer) begin
                if (iCoeffData == words_sum()) m_phase = 3;
                else begin m_phase = 0; m_err = 1'b1; end
            end
            default: begin
                for (int k = 0; k < N; k++) m_bank[16*k +: 16] = m_words[k];
                m_en = 4'hF; m_done = 1'b1; m_phase = 0;
            end
        endcase
    endtask

    task automatic compare_all();
        check("strobe", BW'(oEnSample_300k), BW'(m_cnt == DIV - 1 && m_phase == 0));
        check("busy",   BW'(oBusy),          BW'(m_phase != 0));
        check("ready",  BW'(oCoeffReady),    BW'(m_phase == 1 || m_phase == 2));
        check("en_mul", BW'(oEnMul),         BW'(m_en));
        check("done",   BW'(oLoadDone),      BW'(m_done));
        check("err",    BW'(oLoadErr),       BW'(m_err));
        check("bus",    oCoeffBus,           m_bank);
    endtask

    task automatic cycle();
        @(posedge iClk_12M);
        model_step();
        @(negedge iClk_12M);
        compare_all();
    endtask

    logic [15:0] stim[NT];

    task automatic stim_seq(input int bad_sum);
        int s = 0;
        for (int k = 0; k < N; k++) begin stim[k] = 16'(k + 1); s += k + 1; end
        if (CHK != 0) stim[NT-1] = 16'(s - bad_sum);
    endtask

    task automatic stim_rand(input int bad_sum);
        int s = 0;
        for (int k = 0; k < N; k++) begin stim[k] = 16'($urandom); s += int'(stim[k]); end
        if (CHK != 0) stim[NT-1] = 16'(s - bad_sum);
    endtask

    // vmode: 0 back-to-back, 1 valid toggling, 2 random gaps
    task automatic do_load(input int vmode, input int abort_at, input int restart_at);
        int  p = 0;
        int  xfers = 0;
        int  budget = 0;
        bit  v;
        bit  aborted = 0;
        logic rdy;
        iLoadStart = 1'b1;
        cycle();
        iLoadStart = 1'b0;
        while (p < NT && budget < 2000) begin
            if (p == abort_at) begin
                iCoeffValid = 1'b0;
                iRst = 1'b1;
                cycle();
                iRst = 1'b0;
                aborted = 1;
                break;
            end
            iLoadStart = (p == restart_at);
            case (vmode)
                0:       v = 1'b1;
                1:       v = (budget % 2) == 0;
                default: v = ($urandom % 3) != 0;
            endcase
            iCoeffValid = v;
            iCoeffData  = v ? stim[p] : 16'($urandom);
            rdy = oCoeffReady;
            cycle();
            budget++;
            if (v && rdy) begin p++; xfers++; end
        end
        iCoeffValid = 1'b0;
        iLoadStart  = 1'b0;
        if (aborted) begin
            check("abort_bus", oCoeffBus, '0);
            check("abort_busy", BW'(oBusy), '0);
        end else begin
            check("load_timeout", BW'(budget < 2000), BW'(1));
            check("xfer_count", BW'(xfers), BW'(NT));
        end
        repeat (3) cycle();
    endtask

    task automatic check_seq_bank();
        for (int k = 0; k < N; k++) check("seq_word", BW'(oCoeffBus[16*k +: 16]), BW'(k + 1));
        check("seq_en", BW'(oEnMul), BW'(4'hF));
    endtask

    int strobes;

    initial begin
        repeat (3) cycle();
        iRst = 1'b0;
        check("rst_bus", oCoeffBus, '0);

        strobes = 0;
        for (int c = 0; c < 200; c++) begin
            cycle();
            if (oEnSample_300k) strobes++;
        end
        check("idle_strobes", BW'(strobes), BW'(5));

        stim_seq(0);
        do_load(0, -1, -1);
        check_seq_bank();

        stim_rand(0);
        do_load(0, -1, -1);
        stim_seq(0);
        do_load(1, -1, -1);
        check_seq_bank();

        if (CHK != 0) begin
            stim_seq(1);
            do_load(0, -1, -1);
            check("bad_sum_err", BW'(oLoadErr), BW'(1));
            check("bad_sum_en", BW'(oEnMul), BW'(0));
            for (int k = 0; k < N; k++) check("bad_sum_hold", BW'(oCoeffBus[16*k +: 16]), BW'(k + 1));
            repeat (5) cycle();
            check("err_sticky", BW'(oLoadErr), BW'(1));
        end

        stim_rand(0);
        do_load(0, 6, -1);

        stim_seq(0);
        do_load(0, -1, 3);
        check_seq_bank();

        for (int r = 0; r < 8; r++) begin
            stim_rand((CHK != 0 && ($urandom % 3) == 0) ? int'($urandom_range(1, 100)) : 0);
            do_load(2, -1, ($urandom % 2) != 0 ? int'($urandom_range(0, N - 1)) : -1);
            iCoeffValid = ($urandom % 2) != 0;
            iCoeffData  = 16'($urandom);
            repeat ($urandom_range(0, 50)) cycle();
            iCoeffValid = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
